// File: rtl/arb_pkg.sv
// Types and constants for the memory-port arbiter.
package arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_I = 2'd1,
      LOCK_D = 2'd2
   } arb_state_e;

   localparam logic [1:0] GNT_I = 2'b01;
   localparam logic [1:0] GNT_D = 2'b10;

   // Requester indices, kept stable for a later multi-master arbiter.
   localparam int REQ_I   = 0;
   localparam int REQ_D   = 1;
   localparam int NUM_REQ = 2;
endpackage

// File: rtl/riscv_defines.sv
// Core-wide width constants shared by the RISC-V datapath blocks.
package riscv_defines;
   localparam int RISCV_ADDR_WIDTH = 32;
   localparam int RISCV_WORD_WIDTH = 32;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory handshakes around the arbiter.
interface mem_port_arbiter_if
   import riscv_defines::*;
#(
   parameter int ADDR_W = RISCV_ADDR_WIDTH,
   parameter int DATA_W = RISCV_WORD_WIDTH
);
   logic              i_valid_i;
   logic              i_ready_o;
   logic [ADDR_W-1:0] i_addr_i;
   logic [DATA_W-1:0] i_rdata_o;
   logic              d_valid_i;
   logic              d_ready_o;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic [3:0]        d_we_i;
   logic [DATA_W-1:0] d_rdata_o;
   logic              mem_valid_o;
   logic              mem_ready_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [3:0]        mem_we_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic [1:0]        gnt_o;

   modport slave (
      input  i_valid_i, i_addr_i, d_valid_i, d_addr_i, d_wdata_i, d_we_i,
             mem_ready_i, mem_rdata_i,
      output i_ready_o, i_rdata_o, d_ready_o, d_rdata_o,
             mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o, gnt_o
   );

   modport master (
      output i_valid_i, i_addr_i, d_valid_i, d_addr_i, d_wdata_i, d_we_i,
             mem_ready_i, mem_rdata_i,
      input  i_ready_o, i_rdata_o, d_ready_o, d_rdata_o,
             mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o, gnt_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the instruction-memory port between fetch (I) and LSU (D).
// D has priority, bounded by a streak counter that lets a waiting I through.
//
//   state  | meaning
//   IDLE   | arbitrate combinationally this cycle; zero-wait transfers complete here
//   LOCK_I | fetch transfer in flight, grant held to I until ready or abort
//   LOCK_D | LSU transfer in flight, grant held to D until ready or abort
module mem_port_arbiter
   import arb_pkg::*;
   import riscv_defines::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = RISCV_ADDR_WIDTH,
   parameter int DATA_W       = RISCV_WORD_WIDTH
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam int              SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

   arb_state_e    state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          sel_i, sel_d;
   logic          done_i, done_d;

   always_comb begin
      sel_i = 1'b0;
      sel_d = 1'b0;
      case (state_q)
         IDLE: begin
            sel_d = bus.d_valid_i && !(bus.i_valid_i && (streak_q == LIMIT));
            sel_i = !sel_d && bus.i_valid_i;
         end
         LOCK_I:  sel_i = bus.i_valid_i;
         LOCK_D:  sel_d = bus.d_valid_i;
         default: ;
      endcase
      // Nothing may reach the memory while reset is asserted, even with requests pending.
      if (!rst_n) begin
         sel_i = 1'b0;
         sel_d = 1'b0;
      end
   end

   assign done_i = sel_i && bus.mem_ready_i;
   assign done_d = sel_d && bus.mem_ready_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sel_d && !bus.mem_ready_i)      state_d = LOCK_D;
            else if (sel_i && !bus.mem_ready_i) state_d = LOCK_I;
         end
         // A dropped valid is an abort; the other requester waits for the next IDLE cycle.
         LOCK_I:  if (!sel_i || bus.mem_ready_i) state_d = IDLE;
         LOCK_D:  if (!sel_d || bus.mem_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      streak_d = streak_q;
      if (!bus.i_valid_i || done_i)          streak_d = '0;
      else if (done_d && (streak_q != LIMIT)) streak_d = streak_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   assign bus.mem_valid_o = rst_n && (sel_i || sel_d);
   assign bus.gnt_o       = ({2{sel_i}} & GNT_I) | ({2{sel_d}} & GNT_D);
   assign bus.mem_addr_o  = sel_d ? bus.d_addr_i : (sel_i ? bus.i_addr_i : '0);
   assign bus.mem_wdata_o = sel_d ? bus.d_wdata_i : '0;
   assign bus.mem_we_o    = sel_d ? bus.d_we_i : 4'b0000;
   assign bus.i_ready_o   = done_i;
   assign bus.d_ready_o   = done_d;
   assign bus.i_rdata_o   = rst_n ? bus.mem_rdata_i : '0;
   assign bus.d_rdata_o   = rst_n ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
   import arb_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .STARVE_LIMIT(4),
      .ADDR_W      (32),
      .DATA_W      (32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.i_valid_i   = 1'b0;
      bus.d_valid_i   = 1'b0;
      bus.mem_ready_i = 1'b0;
      cyc();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n           = 1'b0;
      bus.i_valid_i   = 1'b1;
      bus.i_addr_i    = 32'h0000_0010;
      bus.d_valid_i   = 1'b1;
      bus.d_addr_i    = 32'h0000_0020;
      bus.d_wdata_i   = 32'h0;
      bus.d_we_i      = 4'b0000;
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = 32'hA5A5_A5A5;

      // Reset with both requesters asserted
      settle();
      check("rst_mem_valid", {31'b0, bus.mem_valid_o}, 32'd0);
      check("rst_gnt", {30'b0, bus.gnt_o}, 32'd0);
      check("rst_i_ready", {31'b0, bus.i_ready_o}, 32'd0);
      check("rst_d_ready", {31'b0, bus.d_ready_o}, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      settle();
      check("post_rst_gnt", {30'b0, bus.gnt_o}, 32'h2);
      check("post_rst_d_ready", {31'b0, bus.d_ready_o}, 32'd1);
      check("post_rst_addr", bus.mem_addr_o, 32'h0000_0020);
      cyc();
      idle();

      // Zero-wait I read
      bus.i_valid_i   = 1'b1;
      bus.i_addr_i    = 32'h0000_0100;
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = 32'hDEAD_BEEF;
      settle();
      check("zw_gnt", {30'b0, bus.gnt_o}, 32'h1);
      check("zw_addr", bus.mem_addr_o, 32'h0000_0100);
      check("zw_we", {28'b0, bus.mem_we_o}, 32'd0);
      check("zw_i_ready", {31'b0, bus.i_ready_o}, 32'd1);
      check("zw_i_rdata", bus.i_rdata_o, 32'hDEAD_BEEF);
      check("zw_mem_valid", {31'b0, bus.mem_valid_o}, 32'd1);
      cyc();
      idle();

      // Wait states with D contention arriving mid-transfer
      bus.i_valid_i   = 1'b1;
      bus.i_addr_i    = 32'h0000_0200;
      bus.mem_ready_i = 1'b0;
      settle();
      check("ws_c1_gnt", {30'b0, bus.gnt_o}, 32'h1);
      check("ws_c1_i_ready", {31'b0, bus.i_ready_o}, 32'd0);
      cyc();
      bus.d_valid_i = 1'b1;
      bus.d_addr_i  = 32'h0000_0300;
      settle();
      check("ws_c2_gnt", {30'b0, bus.gnt_o}, 32'h1);
      check("ws_c2_addr", bus.mem_addr_o, 32'h0000_0200);
      check("ws_c2_d_ready", {31'b0, bus.d_ready_o}, 32'd0);
      cyc();
      check("ws_c3_gnt", {30'b0, bus.gnt_o}, 32'h1);
      cyc();
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = 32'h1111_2222;
      settle();
      check("ws_c4_gnt", {30'b0, bus.gnt_o}, 32'h1);
      check("ws_c4_i_ready", {31'b0, bus.i_ready_o}, 32'd1);
      check("ws_c4_d_ready", {31'b0, bus.d_ready_o}, 32'd0);
      cyc();
      bus.i_valid_i = 1'b0;
      settle();
      check("ws_next_gnt", {30'b0, bus.gnt_o}, 32'h2);
      check("ws_next_addr", bus.mem_addr_o, 32'h0000_0300);
      check("ws_next_d_ready", {31'b0, bus.d_ready_o}, 32'd1);
      cyc();
      idle();

      // Starvation bound, limit 4: D,D,D,D,I repeating
      bus.i_valid_i   = 1'b1;
      bus.i_addr_i    = 32'h0000_0400;
      bus.d_valid_i   = 1'b1;
      bus.d_addr_i    = 32'h0000_0500;
      bus.mem_ready_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         settle();
         check($sformatf("starve_gnt_%0d", k), {30'b0, bus.gnt_o},
               (k % 5 == 4) ? 32'h1 : 32'h2);
         check($sformatf("starve_streak_%0d", k), 32'(dut.streak_q), 32'(k % 5));
         cyc();
      end
      idle();

      // Abort of a locked I transfer, with ready arriving in the abort cycle
      bus.i_valid_i   = 1'b1;
      bus.i_addr_i    = 32'h0000_0600;
      bus.mem_ready_i = 1'b0;
      settle();
      check("ab_lock_gnt", {30'b0, bus.gnt_o}, 32'h1);
      cyc();
      bus.d_valid_i = 1'b1;
      bus.d_addr_i  = 32'h0000_0700;
      settle();
      check("ab_held_gnt", {30'b0, bus.gnt_o}, 32'h1);
      cyc();
      bus.i_valid_i   = 1'b0;
      bus.mem_ready_i = 1'b1;
      settle();
      check("ab_mem_valid", {31'b0, bus.mem_valid_o}, 32'd0);
      check("ab_gnt", {30'b0, bus.gnt_o}, 32'd0);
      check("ab_i_ready", {31'b0, bus.i_ready_o}, 32'd0);
      check("ab_d_ready", {31'b0, bus.d_ready_o}, 32'd0);
      cyc();
      check("ab_state", {30'b0, dut.state_q}, {30'b0, IDLE});
      check("ab_next_gnt", {30'b0, bus.gnt_o}, 32'h2);
      check("ab_next_addr", bus.mem_addr_o, 32'h0000_0700);
      cyc();
      idle();

      // D write, then an I grant must zero the write fields
      bus.d_valid_i   = 1'b1;
      bus.d_addr_i    = 32'h0000_2004;
      bus.d_wdata_i   = 32'h1234_5678;
      bus.d_we_i      = 4'b0011;
      bus.mem_ready_i = 1'b0;
      settle();
      check("wr_we", {28'b0, bus.mem_we_o}, 32'h3);
      check("wr_wdata", bus.mem_wdata_o, 32'h1234_5678);
      check("wr_addr", bus.mem_addr_o, 32'h0000_2004);
      check("wr_d_ready_wait", {31'b0, bus.d_ready_o}, 32'd0);
      cyc();
      bus.mem_ready_i = 1'b1;
      settle();
      check("wr_d_ready", {31'b0, bus.d_ready_o}, 32'd1);
      check("wr_locked_gnt", {30'b0, bus.gnt_o}, 32'h2);
      cyc();
      bus.d_valid_i = 1'b0;
      bus.i_valid_i = 1'b1;
      bus.i_addr_i  = 32'h0000_0800;
      settle();
      check("wr_i_gnt", {30'b0, bus.gnt_o}, 32'h1);
      check("wr_i_we", {28'b0, bus.mem_we_o}, 32'd0);
      check("wr_i_wdata", bus.mem_wdata_o, 32'd0);
      check("wr_i_ready", {31'b0, bus.i_ready_o}, 32'd1);
      cyc();
      idle();

      // Asynchronous reset in the middle of a locked transfer
      bus.i_valid_i   = 1'b1;
      bus.i_addr_i    = 32'h0000_0900;
      bus.mem_ready_i = 1'b0;
      cyc();
      check("ar_locked_state", {30'b0, dut.state_q}, {30'b0, LOCK_I});
      rst_n = 1'b0;
      settle();
      check("ar_mem_valid", {31'b0, bus.mem_valid_o}, 32'd0);
      check("ar_gnt", {30'b0, bus.gnt_o}, 32'd0);
      check("ar_state", {30'b0, dut.state_q}, {30'b0, IDLE});
      check("ar_addr", bus.mem_addr_o, 32'd0);
      cyc();
      rst_n = 1'b1;
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
